tlb_pipe_cam: RTL

//  Parametrised, fully-associative LoongArch TLB with N registered search ports, a registered read port
//  and a single-cycle write/INVTLB port. Successor of the 16-entry/2-port TLB: depth and port count are

---
 rtl/tlb_pipe_cam_if.sv | 46 ++++
 rtl/tlb_pipe_cam.sv | 138 +++++++++++++
 2 files changed

// File: rtl/tlb_pipe_cam_if.sv
// tlb_pipe_cam_if: bus bundle between the TLB and its users (IF/MEM search
// ports, CSR read/write/INVTLB path, TLBFILL index).
//   slave  modport : the TLB itself
//   master modport : the requesting side
// Signal names and widths follow the TLB port list; clk/resetn stay outside.
interface tlb_pipe_cam_if #(
  parameter int TLBNUM = 16,
  parameter int NSRCH  = 2
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam int RESW = IDXW + 35;

  logic [NSRCH-1:0]      s_req;
  logic [19*NSRCH-1:0]   s_vppn;
  logic [NSRCH-1:0]      s_va_bit12;
  logic [10*NSRCH-1:0]   s_asid;
  logic [NSRCH-1:0]      s_rvalid;
  logic [RESW*NSRCH-1:0] s_res;
  logic                  we;
  logic [IDXW-1:0]       w_index;
  logic [88:0]           w_entry;
  logic                  r_req;
  logic [IDXW-1:0]       r_index;
  logic                  r_rvalid;
  logic [88:0]           r_entry;
  logic                  invtlb_valid;
  logic [4:0]            invtlb_op;
  logic [9:0]            invtlb_asid;
  logic [18:0]           invtlb_vppn;
  logic                  invtlb_err;
  logic [IDXW-1:0]       fill_index;

  modport slave (
    input  s_req, s_vppn, s_va_bit12, s_asid,
    input  we, w_index, w_entry, r_req, r_index,
    input  invtlb_valid, invtlb_op, invtlb_asid, invtlb_vppn,
    output s_rvalid, s_res, r_rvalid, r_entry, invtlb_err, fill_index
  );

  modport master (
    output s_req, s_vppn, s_va_bit12, s_asid,
    output we, w_index, w_entry, r_req, r_index,
    output invtlb_valid, invtlb_op, invtlb_asid, invtlb_vppn,
    input  s_rvalid, s_res, r_rvalid, r_entry, invtlb_err, fill_index
  );
endinterface

// File: rtl/tlb_pipe_cam.sv
// tlb_pipe_cam: fully-associative LoongArch TLB.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : NSRCH registered search ports (1-cycle latency), registered
//                 read port, single-cycle write / INVTLB, INVTLB error pulse,
//                 free-running TLBFILL index.
// Entry : {e,vppn[19],asid[10],g,ps[6],ppn0[20],plv0,mat0,d0,v0,ppn1[20],plv1,mat1,d1,v1}
// Result: {1'b0,multi_hit,found,index[IDXW],ppn[20],ps[6],plv[2],mat[2],d,v}
//         The top bit is a zero pad so the result width stays IDXW+35.
module tlb_pipe_cam #(
  parameter int TLBNUM = 16,
  parameter int NSRCH  = 2
) (
  input logic            clk,
  input logic            resetn,
  tlb_pipe_cam_if.slave  bus
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam int RESW = IDXW + 35;

  // Only e is reset; the payload arrays are plain storage.
  logic [TLBNUM-1:0] e_q;
  logic [TLBNUM-1:0] g_q;
  logic [TLBNUM-1:0] ps4m_q;
  logic [18:0]       vppn_q  [TLBNUM];
  logic [9:0]        asid_q  [TLBNUM];
  logic [25:0]       half0_q [TLBNUM];  // {ppn0,plv0,mat0,d0,v0}
  logic [25:0]       half1_q [TLBNUM];  // {ppn1,plv1,mat1,d1,v1}

  logic [TLBNUM-1:0] inv_hit;
  logic [TLBNUM-1:0] inv_va_m;
  logic [TLBNUM-1:0] inv_asid_m;
  logic [RESW-1:0]   res_d [NSRCH];

  always_ff @(posedge clk) begin
    if (bus.we) begin
      vppn_q[bus.w_index]  <= bus.w_entry[87:69];
      asid_q[bus.w_index]  <= bus.w_entry[68:59];
      g_q[bus.w_index]     <= bus.w_entry[58];
      ps4m_q[bus.w_index]  <= (bus.w_entry[57:52] == 6'd21);
      half0_q[bus.w_index] <= bus.w_entry[51:26];
      half1_q[bus.w_index] <= bus.w_entry[25:0];
    end
  end

  // INVTLB selection; unknown ops select nothing.
  always_comb begin
    inv_hit    = '0;
    inv_va_m   = '0;
    inv_asid_m = '0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      inv_va_m[i]   = (bus.invtlb_vppn[18:9] == vppn_q[i][18:9]) &&
                      (ps4m_q[i] || (bus.invtlb_vppn[8:0] == vppn_q[i][8:0]));
      inv_asid_m[i] = (bus.invtlb_asid == asid_q[i]);
      case (bus.invtlb_op)
        5'd0, 5'd1: inv_hit[i] = 1'b1;
        5'd2:       inv_hit[i] = g_q[i];
        5'd3:       inv_hit[i] = !g_q[i];
        5'd4:       inv_hit[i] = !g_q[i] && inv_asid_m[i];
        5'd5:       inv_hit[i] = !g_q[i] && inv_asid_m[i] && inv_va_m[i];
        5'd6:       inv_hit[i] = (g_q[i] || inv_asid_m[i]) && inv_va_m[i];
        default:    inv_hit[i] = 1'b0;
      endcase
    end
  end

  // A write wins over INVTLB for its own index.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q <= '0;
    end else begin
      for (int unsigned i = 0; i < TLBNUM; i++) begin
        if (bus.we && (bus.w_index == IDXW'(i)))
          e_q[i] <= bus.w_entry[88];
        else if (bus.invtlb_valid && inv_hit[i])
          e_q[i] <= 1'b0;
      end
    end
  end

  // Search: lowest matching index wins, any further match flags multi_hit.
  always_comb begin
    logic [18:0]     vp;
    logic [9:0]      as;
    logic            found;
    logic            multi;
    logic            odd;
    logic [IDXW-1:0] idx;
    logic [25:0]     page;
    for (int unsigned k = 0; k < NSRCH; k++) begin
      vp    = bus.s_vppn[k*19 +: 19];
      as    = bus.s_asid[k*10 +: 10];
      found = 1'b0;
      multi = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < TLBNUM; i++) begin
        if (e_q[i] && (vp[18:9] == vppn_q[i][18:9]) &&
            (ps4m_q[i] || (vp[8:0] == vppn_q[i][8:0])) &&
            (g_q[i] || (as == asid_q[i]))) begin
          if (found) begin
            multi = 1'b1;
          end else begin
            found = 1'b1;
            idx   = IDXW'(i);
          end
        end
      end
      odd      = ps4m_q[idx] ? vp[8] : bus.s_va_bit12[k];
      page     = odd ? half1_q[idx] : half0_q[idx];
      res_d[k] = found ? {1'b0, multi, 1'b1, idx, page[25:6],
                          (ps4m_q[idx] ? 6'd21 : 6'd12), page[5:0]} : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.s_rvalid   <= '0;
      bus.s_res      <= '0;
      bus.r_rvalid   <= 1'b0;
      bus.r_entry    <= '0;
      bus.invtlb_err <= 1'b0;
      bus.fill_index <= '0;
    end else begin
      bus.s_rvalid <= bus.s_req;
      for (int unsigned k = 0; k < NSRCH; k++)
        if (bus.s_req[k]) bus.s_res[k*RESW +: RESW] <= res_d[k];
      bus.r_rvalid <= bus.r_req;
      if (bus.r_req)
        bus.r_entry <= {e_q[bus.r_index], vppn_q[bus.r_index], asid_q[bus.r_index],
                        g_q[bus.r_index], (ps4m_q[bus.r_index] ? 6'd21 : 6'd12),
                        half0_q[bus.r_index], half1_q[bus.r_index]};
      bus.invtlb_err <= bus.invtlb_valid && (bus.invtlb_op > 5'd6);
      if (bus.fill_index == IDXW'(TLBNUM - 1))
        bus.fill_index <= '0;
      else
        bus.fill_index <= bus.fill_index + 1'b1;
    end
  end
endmodule
